// File: rtl/j1_io_mailbox.sv
// J1 io-bus mailbox: TX/RX FIFOs between firmware and fabric streams,
// with STATUS and CTRL registers decoded at BASE..BASE+7.
module j1_io_mailbox #(
  parameter logic [15:0] BASE       = 16'h8000,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        io_sel,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [15:0] rx_data,
  output logic        rx_ready
);

  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [AW-1:0] P1 = 1;
  localparam logic [CW-1:0] C1 = 1;
  localparam logic [CW-1:0] CFULL = CW'(DEPTH);

  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf, rx_unf;

  logic [1:0] off;
  logic sel_tx, sel_rx, sel_st, sel_ctrl;
  logic tx_full, rx_full, rx_nonempty;
  logic tx_push_req, tx_push, tx_pop, tx_flush;
  logic rx_rd_req, rx_push, rx_pop, rx_flush;
  logic ovf_set, unf_set, flag_clr;

  assign io_sel   = (io_addr & 16'hFFF8) == (BASE & 16'hFFF8);
  assign off      = 2'((io_addr & 16'h0006) >> 1);
  assign sel_tx   = io_sel && off == 2'd0;
  assign sel_rx   = io_sel && off == 2'd1;
  assign sel_st   = io_sel && off == 2'd2;
  assign sel_ctrl = io_sel && off == 2'd3;

  assign tx_full     = tx_count == CFULL;
  assign rx_full     = rx_count == CFULL;
  assign rx_nonempty = rx_count != '0;

  assign tx_valid = tx_count != '0;
  assign tx_data  = tx_valid ? tx_mem[tx_rptr] : 16'h0000;
  assign rx_ready = !rx_full;

  // A full TX FIFO still accepts a write when the fabric pops that cycle
  assign tx_pop      = tx_valid && tx_ready;
  assign tx_push_req = io_wr && sel_tx;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_flush    = io_wr && sel_ctrl && io_wdata[0];
  assign ovf_set     = tx_push_req && tx_full && !tx_pop;

  assign rx_push   = rx_valid && rx_ready;
  assign rx_rd_req = io_rd && sel_rx;
  assign rx_pop    = rx_rd_req && rx_nonempty;
  assign rx_flush  = io_wr && sel_ctrl && io_wdata[1];
  assign unf_set   = rx_rd_req && !rx_nonempty;
  assign flag_clr  = io_wr && sel_ctrl && io_wdata[2];

  always_comb begin
    io_rdata = 16'h0000;
    if (sel_rx && rx_nonempty)
      io_rdata = rx_mem[rx_rptr];
    else if (sel_st)
      io_rdata = {8'(rx_count), 4'b0000,
                  rx_unf, tx_ovf, tx_full, rx_nonempty};
  end

  always_ff @(posedge sys_clk_i) begin
    if (tx_push) tx_mem[tx_wptr] <= io_wdata;
    if (rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else if (tx_flush) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + P1;
      if (tx_pop)  tx_rptr <= tx_rptr + P1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + C1;
      else if (tx_pop && !tx_push) tx_count <= tx_count - C1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else if (rx_flush) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + P1;
      if (rx_pop)  rx_rptr <= rx_rptr + P1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + C1;
      else if (rx_pop && !rx_push) rx_count <= rx_count - C1;
    end
  end

  // Clear has priority over a same-cycle set
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i || flag_clr) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (ovf_set) tx_ovf <= 1'b1;
      if (unf_set) rx_unf <= 1'b1;
    end
  end

endmodule
